// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 initiator and responder: sizes, reset
// configuration, FSM states and the config-word channel decode.
`timescale 1ns/1ps
package adc_pkg;

  localparam int DATA_W = 12;
  localparam int CFG_W  = 6;
  localparam int NUM_CH = 8;

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended CH0, unipolar
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WAIT_LOW,
    SHIFT
  } adc_state_t;

  // Differential mode is not modelled, so O/S only selects the odd channel
  // when the word asks for a single-ended input.
  function automatic logic [2:0] cfg_to_channel(input logic [CFG_W-1:0] cfg);
    return {cfg[3], cfg[2], cfg[5] & cfg[4]};
  endfunction

endpackage

// File: rtl/ltc2308_responder_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall pulses
// decoded from the settled stage so the level and the pulses always agree.
`timescale 1ns/1ps
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ltc2308_responder.sv
// Chip-side model of the LTC2308: times a conversion after CONVST, shifts the
// result out on DOUT and captures the next frame's config word from DIN.
`timescale 1ns/1ps
module ltc2308_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                ADC_CONVST,
  input  logic                ADC_SCLK,
  input  logic                ADC_DIN,
  output logic                ADC_DOUT,
  input  logic [8*DATA_W-1:0] CH_DATA,
  output logic [CFG_W-1:0]    CFG_WORD,
  output logic                CFG_VALID,
  output logic                BUSY,
  output logic                FRAME_ERR
);

  import adc_pkg::*;

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  CFG_BITS  = BIT_W'(CFG_W);
  localparam logic [BIT_W-1:0]  DATA_BITS = BIT_W'(DATA_W);
  localparam logic [DATA_W-1:0] SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

  logic convst_level, convst_rise, convst_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic din_level, din_rise_unused, din_fall_unused;

  sync_edge u_sync_convst (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .async_in (ADC_CONVST),
    .level    (convst_level),
    .rise     (convst_rise),
    .fall     (convst_fall)
  );

  sync_edge u_sync_sclk (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .async_in (ADC_SCLK),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge u_sync_din (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .async_in (ADC_DIN),
    .level    (din_level),
    .rise     (din_rise_unused),
    .fall     (din_fall_unused)
  );

  adc_state_t         state_q, state_d;
  logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [CFG_W-1:0]   cfg_shift_q, cfg_shift_d;
  logic [CFG_W-1:0]   cfg_word_q, cfg_word_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;

  logic [2:0]         ch_sel;
  logic [DATA_W-1:0]  ch_value;
  logic [DATA_W-1:0]  coded_result;

  // The word latched at CONVST always uses the config from the previous frame.
  assign ch_sel       = cfg_to_channel(cfg_word_q);
  assign ch_value     = CH_DATA[ch_sel*DATA_W +: DATA_W];
  assign coded_result = cfg_word_q[1] ? ch_value : (ch_value ^ SIGN_FLIP);

  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    result_d    = result_q;
    cfg_shift_d = cfg_shift_q;
    cfg_word_d  = cfg_word_q;
    cfg_valid_d = 1'b0;
    dout_d      = dout_q;
    busy_d      = busy_q;
    frame_err_d = frame_err_q;

    unique case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        if (convst_rise) begin
          state_d     = CONVERT;
          result_d    = coded_result;
          conv_cnt_d  = '0;
          frame_err_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      CONVERT: begin
        conv_cnt_d = conv_cnt_q + 1'b1;
        if (sclk_rise || sclk_fall) begin
          frame_err_d = 1'b1;
        end
        if (conv_cnt_q == CONV_LAST) begin
          busy_d     = 1'b0;
          conv_cnt_d = '0;
          if (!convst_level) begin
            state_d   = SHIFT;
            dout_d    = result_q[DATA_W-1];
            bit_cnt_d = '0;
          end else begin
            state_d = WAIT_LOW;
          end
        end
      end

      WAIT_LOW: begin
        if (convst_fall) begin
          state_d   = SHIFT;
          dout_d    = result_q[DATA_W-1];
          bit_cnt_d = '0;
        end
      end

      SHIFT: begin
        // A new CONVST wins over any coincident SCLK edge and abandons the frame.
        if (convst_rise) begin
          state_d     = CONVERT;
          result_d    = coded_result;
          conv_cnt_d  = '0;
          frame_err_d = 1'b1;
          busy_d      = 1'b1;
          dout_d      = 1'b0;
        end else if (sclk_rise) begin
          if (bit_cnt_q < CFG_BITS) begin
            cfg_shift_d = {cfg_shift_q[CFG_W-2:0], din_level};
          end
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q >= DATA_BITS) begin
            state_d     = IDLE;
            dout_d      = 1'b0;
            cfg_word_d  = cfg_shift_q;
            cfg_valid_d = 1'b1;
          end else begin
            dout_d   = result_q[DATA_W-2];
            result_d = {result_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      conv_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      result_q    <= '0;
      cfg_shift_q <= '0;
      cfg_word_q  <= CFG_RESET;
      cfg_valid_q <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      result_q    <= result_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_word_q  <= cfg_word_d;
      cfg_valid_q <= cfg_valid_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ADC_DOUT  = dout_q;
  assign CFG_WORD  = cfg_word_q;
  assign CFG_VALID = cfg_valid_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Scoreboard bench for ltc2308_responder: frames push expected DOUT words and
// config words; monitors pop and compare as the responder presents them.
`timescale 1ns/1ps
module tb_ltc2308_responder;

  logic        CLOCK_50   = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        ADC_CONVST = 1'b0;
  logic        ADC_SCLK   = 1'b0;
  logic        ADC_DIN    = 1'b0;
  logic        ADC_DOUT;
  logic [95:0] CH_DATA    = '0;
  logic [5:0]  CFG_WORD;
  logic        CFG_VALID;
  logic        BUSY;
  logic        FRAME_ERR;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] exp_dout_q[$];
  logic [5:0]  exp_cfg_q[$];

  logic        frame_active = 1'b0;
  int          bit_count    = 0;
  logic [11:0] dout_word    = '0;
  int          busy_len     = 0;
  logic        cfg_valid_prev = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  ltc2308_responder dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .ADC_CONVST (ADC_CONVST),
    .ADC_SCLK   (ADC_SCLK),
    .ADC_DIN    (ADC_DIN),
    .ADC_DOUT   (ADC_DOUT),
    .CH_DATA    (CH_DATA),
    .CFG_WORD   (CFG_WORD),
    .CFG_VALID  (CFG_VALID),
    .BUSY       (BUSY),
    .FRAME_ERR  (FRAME_ERR)
  );

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic sclk_cycle(input logic din_bit, input int half);
    ADC_DIN = din_bit;
    wait_clks(half);
    ADC_SCLK = 1'b1;
    wait_clks(half);
    ADC_SCLK = 1'b0;
  endtask

  // Drives nbits SCLK periods at 1 MHz; DIN carries cfg MSB first, then zeros.
  task automatic shift_bits(input logic [5:0] cfg, input int nbits);
    frame_active = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      sclk_cycle((i < 6) ? cfg[5-i] : 1'b0, 25);
    end
    frame_active = 1'b0;
    ADC_DIN = 1'b0;
  endtask

  task automatic convst_pulse();
    ADC_CONVST = 1'b1;
    wait_clks(4);
    ADC_CONVST = 1'b0;
  endtask

  task automatic apply_frame(input logic [5:0] cfg, input logic [11:0] exp_word, input logic [5:0] exp_cfg);
    exp_dout_q.push_back(exp_word);
    exp_cfg_q.push_back(exp_cfg);
    convst_pulse();
    wait_clks(100);
    shift_bits(cfg, 12);
    wait_clks(10);
  endtask

  // DOUT collector: one bit per SCLK rise, a word is complete after 12.
  always @(posedge ADC_SCLK or negedge frame_active) begin
    if (!frame_active) begin
      bit_count = 0;
    end else begin
      dout_word = {dout_word[10:0], ADC_DOUT};
      bit_count++;
      if (bit_count == 12) begin
        if (exp_dout_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL dout_word: got %0h, expected nothing queued", dout_word);
        end else begin
          check_value("dout_word", 32'(dout_word), 32'(exp_dout_q.pop_front()));
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (CFG_VALID) begin
      check_value("cfg_valid_pulse", 32'(cfg_valid_prev), 32'd0);
      if (exp_cfg_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL cfg_word: got %0h, expected no update", CFG_WORD);
      end else begin
        check_value("cfg_word", 32'(CFG_WORD), 32'(exp_cfg_q.pop_front()));
      end
    end
    cfg_valid_prev = CFG_VALID;
  end

  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      busy_len = 0;
    end else if (BUSY) begin
      busy_len++;
    end else if (busy_len != 0) begin
      check_value("busy_len", 32'(busy_len), 32'd80);
      busy_len = 0;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      CH_DATA[12*i +: 12] = 12'(12'h5A0 + i);
    end
    CH_DATA[11:0]  = 12'hABC;
    CH_DATA[23:12] = 12'h123;

    wait_clks(3);
    check_value("rst_dout",      32'(ADC_DOUT),  32'd0);
    check_value("rst_cfg_word",  32'(CFG_WORD),  32'h22);
    check_value("rst_cfg_valid", 32'(CFG_VALID), 32'd0);
    check_value("rst_busy",      32'(BUSY),      32'd0);
    check_value("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    RESET_N = 1'b1;
    wait_clks(5);

    // Reset config selects ch0 unipolar; the frame loads ch1 for the next one.
    apply_frame(6'b110010, 12'hABC, 6'b110010);
    apply_frame(6'b100000, 12'h123, 6'b100000);

    CH_DATA[11:0] = 12'h7FF;
    apply_frame(6'b100010, 12'hFFF, 6'b100010);

    // SCLK activity during the conversion window.
    exp_dout_q.push_back(12'h7FF);
    exp_cfg_q.push_back(6'b110010);
    convst_pulse();
    wait_clks(6);
    sclk_cycle(1'b1, 5);
    sclk_cycle(1'b1, 5);
    ADC_DIN = 1'b0;
    wait_clks(10);
    check_value("conv_sclk_frame_err", 32'(FRAME_ERR), 32'd1);
    check_value("conv_sclk_dout",      32'(ADC_DOUT),  32'd0);
    check_value("conv_sclk_cfg",       32'(CFG_WORD),  32'h22);
    wait_clks(70);
    shift_bits(6'b110010, 12);
    wait_clks(10);
    check_value("frame_err_sticky", 32'(FRAME_ERR), 32'd1);

    // Abort after 5 SCLK periods; the follow-up frame uses the unchanged config.
    exp_dout_q.push_back(12'h123);
    exp_cfg_q.push_back(6'b010010);
    convst_pulse();
    wait_clks(4);
    check_value("convst_clears_frame_err", 32'(FRAME_ERR), 32'd0);
    wait_clks(96);
    shift_bits(6'b101101, 5);
    ADC_CONVST = 1'b1;
    wait_clks(6);
    check_value("abort_frame_err", 32'(FRAME_ERR), 32'd1);
    check_value("abort_cfg",       32'(CFG_WORD),  32'h32);
    check_value("abort_busy",      32'(BUSY),      32'd1);
    ADC_CONVST = 1'b0;
    wait_clks(100);
    shift_bits(6'b010010, 12);
    wait_clks(10);
    check_value("abort_frame_err_kept", 32'(FRAME_ERR), 32'd1);

    // S/D=0 with O/S=1 still selects ch0; reset part-way through the frame.
    CH_DATA[11:0] = 12'hABC;
    convst_pulse();
    wait_clks(100);
    shift_bits(6'b111111, 2);
    wait_clks(5);
    check_value("mid_shift_dout", 32'(ADC_DOUT), 32'd1);
    check_value("mid_shift_cfg",  32'(CFG_WORD), 32'h12);
    @(negedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    #1;
    check_value("async_rst_dout",      32'(ADC_DOUT),  32'd0);
    check_value("async_rst_cfg",       32'(CFG_WORD),  32'h22);
    check_value("async_rst_frame_err", 32'(FRAME_ERR), 32'd0);
    check_value("async_rst_busy",      32'(BUSY),      32'd0);
    wait_clks(3);
    RESET_N = 1'b1;
    wait_clks(5);
    apply_frame(6'b110010, 12'hABC, 6'b110010);

    wait_clks(20);
    check_value("dout_queue_empty", 32'(exp_dout_q.size()), 32'd0);
    check_value("cfg_queue_empty",  32'(exp_cfg_q.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ltc2308_responder.md
Name: ltc2308_responder

Overview:
Synthesizable responder model of the LTC2308 SPI ADC, i.e. the chip side of the ADC_CONVST/ADC_SCLK/ADC_DIN/ADC_DOUT interface driven by the adc block.
- Lets the adc initiator be exercised on-board (GPIO loopback) and in simulation with known channel values.
- Detects CONVST, times the conversion, captures the 6-bit config word from DIN and shifts a 12-bit result out on DOUT.
- The channel for each result comes from the config word received in the previous frame (LTC2308 pipelining).

Parameters:
CONV_CYCLES, 80, CLOCK_50 cycles of conversion time (1.6 us).
DATA_W, 12, result width.
CFG_W, 6, config word width.

Ports:
CLOCK_50  input  1  system clock.
RESET_N  input  1  asynchronous active-low reset.
ADC_CONVST  input  1  conversion start from initiator.
ADC_SCLK  input  1  serial clock from initiator; asynchronous to CLOCK_50.
ADC_DIN  input  1  config bits from initiator.
ADC_DOUT  output  1  result bits to initiator.
CH_DATA  input  96  eight 12-bit channel values; CH_DATA[12*i +: 12] is channel i.
CFG_WORD  output  6  active config {S/D,O/S,S1,S0,UNI,SLP}.
CFG_VALID  output  1  one-cycle pulse when CFG_WORD updates.
BUSY  output  1  high while converting.
FRAME_ERR  output  1  sticky protocol-violation flag.

Behaviour:
Clock and reset:
- Single clock CLOCK_50. Reset is asynchronous, active-low (RESET_N).
- Reset values: ADC_DOUT=0, CFG_WORD=6'b100010 (single-ended CH0, unipolar), CFG_VALID=0, BUSY=0, FRAME_ERR=0, state IDLE, all counters 0.

Input synchronisation and timing:
- CONVST, SCLK and DIN each pass through 2-flop synchronisers plus edge detection.
- Every pin-level event acts 3 CLOCK_50 cycles after the pin edge.
- Supported SCLK half-period is at least 4 CLOCK_50 cycles. Faster SCLK is unsupported and not detected.

Channel select and coding:
- Channel = {S1,S0,O/S} of the active CFG_WORD.
- S/D=0 (differential) is not modelled; it returns channel {S1,S0,0}.
- Result = CH_DATA[channel] if UNI=1, else CH_DATA[channel] ^ 12'h800 (offset to two's complement).
- SLP is ignored.

State machine (IDLE, CONVERT, WAIT_LOW, SHIFT):
- IDLE: ADC_DOUT=0.
  - CONVST rise -> CONVERT. Latch the result word, clear conv counter, clear FRAME_ERR.
- CONVERT: BUSY=1; counter increments each cycle.
  - A CONVST fall does not abort the conversion.
  - Any SCLK edge sets FRAME_ERR and is ignored.
  - At count CONV_CYCLES-1: BUSY=0. If synced CONVST=0 -> SHIFT, else -> WAIT_LOW.
- WAIT_LOW: CONVST fall -> SHIFT.
- On entry to SHIFT: ADC_DOUT=result[11]; bit counter=0.
- SHIFT:
  - SCLK rise: while bit counter < 6, shift synced DIN into the config shift register, MSB first. Bit counter increments on every rise.
  - SCLK fall: ADC_DOUT takes the next result bit (MSB first).
  - On the 12th fall: ADC_DOUT=0, CFG_WORD=captured word, CFG_VALID=1 for one cycle, -> IDLE.
  - CONVST rise in SHIFT: frame aborted, FRAME_ERR=1, CFG_WORD unchanged, new result latched with the old config, -> CONVERT. In this case FRAME_ERR is not cleared.
- A simultaneous CONVST rise and SCLK edge is handled as the CONVST event.

Async reset mid-frame: all outputs return to reset values immediately; the partial config word is discarded.

Decomposition:
- Package adc_pkg:
  - constants DATA_W, CFG_W, NUM_CH=8, CFG_RESET=6'b100010;
  - state enum typedef;
  - function cfg_to_channel(cfg) returning the 3-bit channel index.
  - Shared with the adc initiator.
- Sub-module sync_edge: 2-flop synchroniser plus registered rise/fall pulses. Instantiated three times (DIN uses only the level).

Test Plan:
1. Reset; CH_DATA ch0=12'hABC. CONVST pulse, then 12 SCLK at 1 MHz with DIN=6'b110010 then zeros -> DOUT sequence 1010_1011_1100; CFG_WORD=6'b110010 with one CFG_VALID pulse; BUSY high for 80 cycles.
2. Second frame, ch1=12'h123 -> DOUT 0001_0010_0011 (channel from prior config).
3. Config 6'b100000 (UNI=0), ch0=12'h7FF, next frame -> DOUT=12'hFFF.
4. SCLK toggles during CONVERT -> FRAME_ERR=1, DOUT and config unaffected; next CONVST rise clears FRAME_ERR.
5. CONVST rise after 5 SCLK cycles -> FRAME_ERR=1, CFG_WORD unchanged, BUSY=1 for 80 cycles, then a full normal frame.
6. RESET_N low mid-SHIFT -> DOUT=0 and CFG_WORD=6'b100010 without a clock edge; next frame returns ch0.
